// File: rtl/pipe_trace_pkg.sv
// Shared types for the pipeline trace capture block: FSM states, the
// 96-bit trace entry layout and the instruction word treated as a bubble.
package pipe_trace_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } trace_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] walu;
    } trace_entry_t;

    localparam logic [31:0] NOP_INST = 32'h0;

endpackage

// File: rtl/trace_fifo.sv
// Trace entry storage: circular buffer with wrapping pointers, occupancy
// count and a registered head entry so rd_* never come straight off the RAM.
module trace_fifo
    import pipe_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  trace_entry_t wr_entry,
    output trace_entry_t rd_entry,
    output logic         rd_valid,
    output logic [AW:0]  count
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    trace_entry_t  mem [DEPTH];
    trace_entry_t  head_n;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] head_ptr_n;
    logic [AW:0]   left_after_pop;
    logic [AW:0]   count_n;
    logic          push_ok;
    logic          pop_ok;

    assign rd_valid       = (count != '0);
    assign pop_ok         = pop && rd_valid;
    assign push_ok        = push && (count != FULL);
    assign left_after_pop = count - (AW+1)'(pop_ok);
    assign count_n        = left_after_pop + (AW+1)'(push_ok);
    assign head_ptr_n     = rd_ptr + AW'(pop_ok);

    // An entry pushed into an empty (or just-emptied) buffer bypasses the RAM
    // so it is visible on the head register one cycle after the write.
    always_comb begin
        head_n = rd_entry;
        if (push_ok && (left_after_pop == '0)) begin
            head_n = wr_entry;
        end else if (pop_ok) begin
            head_n = mem[head_ptr_n];
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_entry <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr   <= head_ptr_n;
            count    <= count_n;
            rd_entry <= head_n;
        end
    end

endmodule

// File: rtl/pipe_trace_capture.sv
// Trace port for the pipelined CPU: arm, wait for trig_pc, record one entry
// per cycle, drain via valid/ready. `define TRACE_SKIP_BUBBLE_EN to drop bubbles.
module pipe_trace_capture
    import pipe_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arm,
    input  logic        stop,
    input  logic [31:0] trig_pc,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [31:0] walu,
    input  logic        rd_ready,
    output logic        rd_valid,
    output logic [31:0] rd_pc,
    output logic [31:0] rd_inst,
    output logic [31:0] rd_walu,
    output logic [AW:0] count,
    output logic        busy,
    output logic        done
);

    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    trace_state_t state;
    trace_state_t state_n;
    trace_entry_t wr_entry;
    trace_entry_t rd_entry;
    logic         push;
    logic         clr;
    logic         pop;
    logic         skip;
    logic         fills;

`ifdef TRACE_SKIP_BUBBLE_EN
    assign skip = (inst == NOP_INST);
`else
    assign skip = 1'b0;
`endif

    assign wr_entry = '{pc: pc, inst: inst, walu: walu};
    assign pop      = rd_valid && rd_ready;
    // A push this cycle leaves the buffer full only if nothing leaves it too.
    assign fills    = (count == LAST) && !pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        push    = 1'b0;
        clr     = 1'b0;
        case (state)
            IDLE: begin
                if (arm && !stop) begin
                    clr     = 1'b1;
                    state_n = ARMED;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_n = DONE;
                end else if (pc == trig_pc) begin
                    push    = 1'b1;
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (stop) begin
                    state_n = DONE;
                end else if (!skip) begin
                    push = 1'b1;
                    if (fills) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (count == '0) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    trace_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clr     (clr),
        .push    (push),
        .pop     (pop),
        .wr_entry(wr_entry),
        .rd_entry(rd_entry),
        .rd_valid(rd_valid),
        .count   (count)
    );

    assign rd_pc   = rd_entry.pc;
    assign rd_inst = rd_entry.inst;
    assign rd_walu = rd_entry.walu;
    assign busy    = (state == ARMED) || (state == CAPTURE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_pipe_trace_capture.sv
// Bench for pipe_trace_capture: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the trace buffer.
module tb_pipe_trace_capture;

    localparam int DEPTH = 16;
`ifdef TRACE_SKIP_BUBBLE_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        arm;
    logic        stop;
    logic [31:0] trig_pc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] walu;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [31:0] rd_inst;
    logic [31:0] rd_walu;
    logic [4:0]  count;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    // Model: queue of recorded entries plus the phase of the trace session
    // (0 idle, 1 waiting for trigger, 2 recording, 3 finished).
    logic [95:0] m_q[$];
    int          m_mode;

    pipe_trace_capture #(.DEPTH(16), .AW(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .arm     (arm),
        .stop    (stop),
        .trig_pc (trig_pc),
        .pc      (pc),
        .inst    (inst),
        .walu    (walu),
        .rd_ready(rd_ready),
        .rd_valid(rd_valid),
        .rd_pc   (rd_pc),
        .rd_inst (rd_inst),
        .rd_walu (rd_walu),
        .count   (count),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [7:0] exp_ctl();
        return {(m_mode == 1) || (m_mode == 2), m_mode == 3, m_q.size() != 0, 5'(m_q.size())};
    endfunction

    // Drive one cycle of inputs, advance the model, then move to the next falling edge.
    task automatic step(input logic a, input logic s, input logic [31:0] p,
                        input logic [31:0] i, input logic rr);
        bit pop_m;
        bit wr_m;
        arm      = a;
        stop     = s;
        pc       = p;
        inst     = i;
        walu     = $urandom;
        rd_ready = rr;
        pop_m    = (m_q.size() != 0) && rr;
        wr_m     = 1'b0;
        case (m_mode)
            0: if (a && !s) begin m_q.delete(); m_mode = 1; end
            1: if (s) m_mode = 3; else if (p == trig_pc) begin wr_m = 1'b1; m_mode = 2; end
            2: if (s) m_mode = 3; else if (!(SKIP && i == 32'h0)) wr_m = 1'b1;
            3: if (m_q.size() == 0) m_mode = 0;
            default: m_mode = 0;
        endcase
        if (pop_m) void'(m_q.pop_front());
        if (wr_m) begin
            m_q.push_back({p, i, walu});
            if (m_mode == 2 && m_q.size() == DEPTH) m_mode = 3;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && m_mode != 0; k++) step(1'b0, 1'b0, 32'h0, 32'h1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h1, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; arm = 1'b0; stop = 1'b0; trig_pc = '0;
        pc = '0; inst = '0; walu = '0; rd_ready = 1'b0;
        m_q.delete(); m_mode = 0;
        repeat (2) @(negedge clock);
        checks++;
        if ({busy, done, rd_valid, count} !== 8'h0) begin
            failures++; $display("FAIL reset_ctl got=%h want=00", {busy, done, rd_valid, count});
        end
        checks++;
        if ({rd_pc, rd_inst, rd_walu} !== 96'h0) begin
            failures++; $display("FAIL reset_data got=%h want=0", {rd_pc, rd_inst, rd_walu});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic_capture();
        trig_pc = 32'h8;
        step(1'b1, 1'b0, 32'h0, $urandom | 32'h1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b0, 32'(4 * k), $urandom | 32'h1, 1'b0);
            checks++;
            if ({busy, done, rd_valid, count} !== exp_ctl()) begin
                failures++; $display("FAIL basic_ctl k=%0d got=%h want=%h", k, {busy, done, rd_valid, count}, exp_ctl());
            end
            if (m_mode == 3) break;
        end
        checks++;
        if ({count, done, rd_pc} !== {5'd16, 1'b1, 32'h8}) begin
            failures++; $display("FAIL basic_full count=%0d done=%b pc=%h want 16 1 8", count, done, rd_pc);
        end
        for (int k = 0; k < 24; k++) begin
            if (k < 16) begin
                checks++;
                if (rd_pc !== 32'(8 + 4 * k)) begin
                    failures++; $display("FAIL basic_order k=%0d got=%h want=%h", k, rd_pc, 32'(8 + 4 * k));
                end
            end
            step(1'b0, 1'b0, 32'h0, 32'h1, 1'b1);
            checks++;
            if ({busy, done, rd_valid, count} !== exp_ctl()) begin
                failures++; $display("FAIL basic_drain_ctl k=%0d got=%h want=%h", k, {busy, done, rd_valid, count}, exp_ctl());
            end
            if (m_q.size() != 0) begin
                checks++;
                if ({rd_pc, rd_inst, rd_walu} !== m_q[0]) begin
                    failures++; $display("FAIL basic_drain_data got=%h want=%h", {rd_pc, rd_inst, rd_walu}, m_q[0]);
                end
            end
        end
        checks++;
        if ({busy, done, count} !== 7'h0) begin
            failures++; $display("FAIL basic_idle got=%h want=00", {busy, done, count});
        end
    endtask

    task automatic test_early_stop();
        trig_pc = 32'h8;
        step(1'b1, 1'b0, 32'h0, 32'h1, 1'b0);
        for (int k = 0; k <= 5; k++) step(1'b0, 32'(4 * k) == 32'h14, 32'(4 * k), $urandom | 32'h1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 32'h8, $urandom | 32'h1, 1'b0);
            checks++;
            if ({done, count, rd_pc} !== {1'b1, 5'd3, 32'h8}) begin
                failures++; $display("FAIL stop_hold done=%b count=%0d pc=%h want 1 3 8", done, count, rd_pc);
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({rd_valid, rd_pc} !== {1'b1, 32'(8 + 4 * k)}) begin
                failures++; $display("FAIL stop_entry k=%0d got=%h want=%h", k, rd_pc, 32'(8 + 4 * k));
            end
            step(1'b0, 1'b0, 32'h0, 32'h1, 1'b1);
        end
        drain();
    endtask

    task automatic test_concurrent_drain();
        trig_pc = 32'h8;
        step(1'b1, 1'b0, 32'h0, 32'h1, 1'b1);
        for (int k = 0; k <= 30; k++) begin
            step(1'b0, k == 30, 32'(4 * k), $urandom | 32'h1, 1'b1);
            checks++;
            if ({busy, done, rd_valid, count} !== exp_ctl()) begin
                failures++; $display("FAIL conc_ctl k=%0d got=%h want=%h", k, {busy, done, rd_valid, count}, exp_ctl());
            end
            if (k >= 2 && k < 30) begin
                checks++;
                if ({count, rd_pc} !== {5'd1, 32'(4 * k)}) begin
                    failures++; $display("FAIL conc_follow k=%0d count=%0d pc=%h want 1 %h", k, count, rd_pc, 32'(4 * k));
                end
            end
        end
        drain();
        checks++;
        if ({busy, done, count} !== 7'h0) begin
            failures++; $display("FAIL conc_idle got=%h want=00", {busy, done, count});
        end
    endtask

    task automatic test_no_trigger();
        trig_pc = 32'h3;
        step(1'b1, 1'b0, 32'h0, 32'h1, 1'b0);
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 1'b0, $urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 1));
            checks++;
            if ({busy, done, count} !== 7'h40) begin
                failures++; $display("FAIL notrig_wait got=%h want=40", {busy, done, count});
            end
        end
        step(1'b0, 1'b1, 32'h0, 32'h1, 1'b0);
        checks++;
        if ({busy, done, count} !== 7'h20) begin
            failures++; $display("FAIL notrig_stop got=%h want=20", {busy, done, count});
        end
        step(1'b0, 1'b0, 32'h0, 32'h1, 1'b0);
        checks++;
        if ({busy, done, count} !== 7'h00) begin
            failures++; $display("FAIL notrig_idle got=%h want=00", {busy, done, count});
        end
    endtask

    task automatic test_reset_mid();
        trig_pc = 32'h8;
        step(1'b1, 1'b0, 32'h0, 32'h1, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 32'(4 * k), $urandom | 32'h1, 1'b0);
        checks++;
        if ({busy, count} !== {1'b1, 5'd5}) begin
            failures++; $display("FAIL rstmid_pre busy=%b count=%0d want 1 5", busy, count);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, rd_valid, count} !== 8'h0) begin
            failures++; $display("FAIL rstmid_async got=%h want=00", {busy, done, rd_valid, count});
        end
        @(negedge clock);
        reset = 1'b0;
        m_q.delete(); m_mode = 0;
        step(1'b1, 1'b0, 32'h0, 32'h1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b0, k == 35, 32'(4 * $urandom_range(0, 3)), $urandom | 32'h1, $urandom_range(0, 1));
            checks++;
            if ({busy, done, rd_valid, count} !== exp_ctl()) begin
                failures++; $display("FAIL rstmid_rearm k=%0d got=%h want=%h", k, {busy, done, rd_valid, count}, exp_ctl());
            end
            if (m_q.size() != 0) begin
                checks++;
                if ({rd_pc, rd_inst, rd_walu} !== m_q[0]) begin
                    failures++; $display("FAIL rstmid_data got=%h want=%h", {rd_pc, rd_inst, rd_walu}, m_q[0]);
                end
            end
        end
        drain();
    endtask

    task automatic test_bubble();
        logic [31:0] stream [4];
        stream = '{32'h2008_0001, 32'h0, 32'h0, 32'h2108_0001};
        trig_pc = 32'h100;
        step(1'b1, 1'b0, 32'h0, 32'h1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'(32'h100 + 4 * k), stream[k], 1'b0);
        step(1'b0, 1'b1, 32'h110, 32'h1, 1'b0);
        checks++;
        if (count !== (SKIP ? 5'd2 : 5'd4)) begin
            failures++; $display("FAIL bubble_count got=%0d want=%0d", count, SKIP ? 2 : 4);
        end
        for (int k = 0; k < 6 && m_q.size() != 0; k++) begin
            checks++;
            if ({rd_pc, rd_inst, rd_walu} !== m_q[0]) begin
                failures++; $display("FAIL bubble_data got=%h want=%h", {rd_pc, rd_inst, rd_walu}, m_q[0]);
            end
            step(1'b0, 1'b0, 32'h0, 32'h1, 1'b1);
        end
        drain();
    endtask

    task automatic test_random();
        trig_pc = 32'h8;
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0, 32'(4 * $urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, $urandom_range(0, 1));
            checks++;
            if ({busy, done, rd_valid, count} !== exp_ctl()) begin
                failures++; $display("FAIL rand_ctl k=%0d got=%h want=%h", k, {busy, done, rd_valid, count}, exp_ctl());
            end
            if (m_q.size() != 0) begin
                checks++;
                if ({rd_pc, rd_inst, rd_walu} !== m_q[0]) begin
                    failures++; $display("FAIL rand_data k=%0d got=%h want=%h", k, {rd_pc, rd_inst, rd_walu}, m_q[0]);
                end
            end
        end
        drain();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_capture();
        test_early_stop();
        test_concurrent_drain();
        test_no_trigger();
        test_reset_mid();
        test_bubble();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
